// File: rtl/capture_sequencer.sv
// Single-shot acquisition sequencer: fills a circular sample RAM around a level/edge
// trigger (or a timeout), freezes it, then walks the read address from the oldest sample.
module capture_sequencer #(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int TIMEOUT = 500000
) (
  input  logic          osc_clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          continuous,
  input  logic [7:0]    trig_level,
  input  logic          trig_rising,
  input  logic [AW-1:0] pre_count,
  input  logic          sample_valid,
  input  logic [7:0]    sample_data,
  input  logic          rd_step,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [AW-1:0] rd_addr,
  output logic          buf_ready,
  output logic          capturing,
  output logic [AW-1:0] trig_addr,
  output logic          auto_trig,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, pre_cnt, post_cnt, rd_cnt, rd_addr_q, trig_addr_q, pre_q;
  logic [TW-1:0] tmo;
  logic          force_q, first_q, auto_q, rising_q;
  logic [7:0]    prev_q, level_q;

  // Strobes (arm, sample_valid, rd_step) are single-cycle, accepted on the edge they are
  // high for, with no backpressure; outside the states that use them they are dropped.
  logic          cap_st, wr_fire, crossing, force_now, trig_fire, rd_fire, rd_last, start;
  logic          enter_ro;
  logic [7:0]    prev_eff;
  logic [AW-1:0] post_init, rd_base;

  assign cap_st    = (state == S_PRETRIG) || (state == S_ARMED) || (state == S_POST);
  assign wr_fire   = sample_valid && cap_st;
  // The first sample of a capture has no predecessor, so it is compared with itself.
  assign prev_eff  = first_q ? sample_data : prev_q;
  assign crossing  = rising_q ? ((prev_eff < level_q) && (sample_data >= level_q))
                              : ((prev_eff > level_q) && (sample_data <= level_q));
  assign force_now = (TIMEOUT != 0) && (force_q || (tmo == TMO_MAX));
  assign trig_fire = (state == S_ARMED) && sample_valid && (crossing || force_now);
  assign rd_fire   = (state == S_READOUT) && rd_step;
  assign rd_last   = rd_fire && (rd_cnt == LAST);
  assign start     = ((state == S_IDLE) && arm) || (rd_last && continuous);
  assign post_init = LAST - pre_q;
  assign enter_ro  = (state_nxt == S_READOUT) && (state != S_READOUT);
  assign rd_base   = trig_fire ? wr_ptr : trig_addr_q;

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (arm) state_nxt = S_PRETRIG;
      S_PRETRIG: begin
        if (pre_q == '0)
          state_nxt = S_ARMED;
        else if (sample_valid && ((pre_cnt + AW'(1)) == pre_q))
          state_nxt = S_ARMED;
      end
      S_ARMED:   if (trig_fire) state_nxt = (post_init == '0) ? S_READOUT : S_POST;
      S_POST:    if (sample_valid && (post_cnt == AW'(1))) state_nxt = S_READOUT;
      S_READOUT: if (rd_last) state_nxt = continuous ? S_PRETRIG : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    capturing = cap_st;
    buf_ready = (state == S_READOUT);
    wr_en     = wr_fire;
    wr_addr   = wr_ptr;
    wr_data   = wr_fire ? sample_data : 8'h00;
    rd_addr   = rd_addr_q;
    trig_addr = trig_addr_q;
    auto_trig = auto_q;
    state_dbg = state;
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      level_q  <= '0;
      rising_q <= 1'b0;
      pre_q    <= '0;
      wr_ptr   <= '0;
      pre_cnt  <= '0;
      first_q  <= 1'b0;
      prev_q   <= '0;
    end else if (start) begin
      level_q  <= trig_level;
      rising_q <= trig_rising;
      pre_q    <= pre_count;
      wr_ptr   <= '0;
      pre_cnt  <= '0;
      first_q  <= 1'b1;
    end else begin
      if (wr_fire) begin
        wr_ptr  <= wr_ptr + AW'(1);
        prev_q  <= sample_data;
        first_q <= 1'b0;
      end
      if ((state == S_PRETRIG) && sample_valid) pre_cnt <= pre_cnt + AW'(1);
    end
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      trig_addr_q <= '0;
      post_cnt    <= '0;
      auto_q      <= 1'b0;
    end else if (start) begin
      auto_q <= 1'b0;
    end else if (trig_fire) begin
      trig_addr_q <= wr_ptr;
      post_cnt    <= post_init;
      auto_q      <= !crossing;
    end else if ((state == S_POST) && sample_valid) begin
      post_cnt <= post_cnt - AW'(1);
    end
  end

  // Timeout only runs while ARMED; it saturates so force stays latched.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      tmo     <= '0;
      force_q <= 1'b0;
    end else if (state != S_ARMED) begin
      tmo     <= '0;
      force_q <= 1'b0;
    end else begin
      if (tmo != TMO_MAX) tmo <= tmo + TW'(1);
      if ((TIMEOUT != 0) && (tmo == TMO_MAX)) force_q <= 1'b1;
    end
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      rd_cnt    <= '0;
    end else if (enter_ro) begin
      rd_addr_q <= rd_base - pre_q;
      rd_cnt    <= '0;
    end else if (rd_fire) begin
      rd_addr_q <= rd_addr_q + AW'(1);
      rd_cnt    <= rd_cnt + AW'(1);
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: RAM writes and read addresses are checked by a
// negedge monitor against expected queues; state/flag values are checked inline.
module tb_capture_sequencer;
  localparam int DEPTH = 16, AW = 4, TIMEOUT = 100;

  logic          osc_clk = 1'b0, reset = 1'b0, arm = 1'b0, continuous = 1'b0;
  logic [7:0]    trig_level = '0;
  logic          trig_rising = 1'b0;
  logic [AW-1:0] pre_count = '0;
  logic          sample_valid = 1'b0;
  logic [7:0]    sample_data = '0;
  logic          rd_step = 1'b0;
  logic          wr_en, buf_ready, capturing, auto_trig;
  logic [AW-1:0] wr_addr, rd_addr, trig_addr;
  logic [7:0]    wr_data;
  logic [2:0]    state_dbg;

  int errors = 0, checks = 0;
  logic [AW+7:0] exp_wr_q[$];
  logic [AW-1:0] exp_rd_q[$];
  logic [AW-1:0] m_wa = '0, m_ra = '0;

  capture_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .osc_clk(osc_clk), .reset(reset), .arm(arm), .continuous(continuous),
    .trig_level(trig_level), .trig_rising(trig_rising), .pre_count(pre_count),
    .sample_valid(sample_valid), .sample_data(sample_data), .rd_step(rd_step),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .buf_ready(buf_ready), .capturing(capturing), .trig_addr(trig_addr),
    .auto_trig(auto_trig), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 osc_clk = ~osc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge osc_clk) begin
    logic [AW+7:0] ew;
    logic [AW-1:0] er;
    if (wr_en) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", wr_addr, wr_data);
      end else begin
        ew = exp_wr_q.pop_front();
        if ({wr_addr, wr_data} !== ew) begin
          errors++;
          $display("FAIL wr: got addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr, wr_data, ew[AW+7:8], ew[7:0]);
        end
      end
    end
    if (rd_step && buf_ready) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rd_addr=%0d, required no readout step", rd_addr);
      end else begin
        er = exp_rd_q.pop_front();
        if (rd_addr !== er) begin
          errors++;
          $display("FAIL rd: got rd_addr=%0d, required %0d", rd_addr, er);
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] d, input bit exp_w);
    sample_valid = 1'b1;
    sample_data  = d;
    if (exp_w) begin
      exp_wr_q.push_back({m_wa, d});
      m_wa = m_wa + 1'b1;
    end
    tick();
    sample_valid = 1'b0;
    sample_data  = '0;
  endtask

  task automatic step(input bit exp_r);
    rd_step = 1'b1;
    if (exp_r) begin
      exp_rd_q.push_back(m_ra);
      m_ra = m_ra + 1'b1;
    end
    tick();
    rd_step = 1'b0;
  endtask

  task automatic do_arm(input logic [AW-1:0] pre, input logic [7:0] lvl, input logic rise,
                        input logic cont);
    pre_count   = pre;
    trig_level  = lvl;
    trig_rising = rise;
    continuous  = cont;
    arm = 1'b1;
    tick();
    arm  = 1'b0;
    m_wa = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_buf_ready", buf_ready, 0);
    check("rst_capturing", capturing, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_auto_trig", auto_trig, 0);
    check("rst_state", state_dbg, 0);
    sample_valid = 1'b0;
    sample_data  = '0;
    tick();
    reset = 1'b0;
    tick();
    check("wr_q_drained", exp_wr_q.size(), 0);
    check("rd_q_drained", exp_rd_q.size(), 0);
    exp_wr_q.delete();
    exp_rd_q.delete();
  endtask

  initial begin
    #1;
    do_reset();

    // basic capture, readout of the full buffer from the oldest sample
    do_arm(4, 8'h80, 1'b1, 1'b0);
    check("t1_capturing", capturing, 1);
    check("t1_state_pre", state_dbg, 1);
    sample(8'h10, 1); sample(8'h20, 1); sample(8'h30, 1); sample(8'h40, 1);
    check("t1_state_armed", state_dbg, 2);
    sample(8'h70, 1);
    sample(8'h90, 1);
    check("t1_trig_addr", trig_addr, 5);
    check("t1_state_post", state_dbg, 3);
    check("t1_auto", auto_trig, 0);
    for (int i = 0; i < 10; i++) sample(8'hA0 + 8'(i), 1);
    check("t1_not_ready", buf_ready, 0);
    sample(8'hB0, 1);
    check("t1_ready", buf_ready, 1);
    check("t1_rd_start", rd_addr, 1);
    check("t1_state_ro", state_dbg, 4);
    check("t1_cap_off", capturing, 0);
    sample(8'h33, 0);
    m_ra = 1;
    for (int i = 0; i < 16; i++) step(1);
    check("t1_ready_fall", buf_ready, 0);
    check("t1_state_idle", state_dbg, 0);
    step(0);
    check("t1_rd_hold", rd_addr, 1);
    do_reset();

    // rising edge rules
    do_arm(0, 8'h80, 1'b1, 1'b0);
    tick();
    check("t2_armed", state_dbg, 2);
    sample(8'h80, 1);
    sample(8'h85, 1);
    check("t2_no_trig_80_85", state_dbg, 2);
    sample(8'h7F, 1);
    check("t2_no_trig_fall", state_dbg, 2);
    sample(8'h80, 1);
    check("t2_trig_7f_80", state_dbg, 3);
    check("t2_trig_addr", trig_addr, 3);
    do_reset();

    // falling edge rules
    do_arm(0, 8'h40, 1'b0, 1'b0);
    tick();
    sample(8'h40, 1);
    sample(8'h3F, 1);
    check("t2_no_trig_40_3f", state_dbg, 2);
    sample(8'h41, 1);
    check("t2_no_trig_rise", state_dbg, 2);
    sample(8'h40, 1);
    check("t2_trig_41_40", state_dbg, 3);
    check("t2_fall_trig_addr", trig_addr, 3);
    do_reset();

    // write pointer wrap, trigger at 6 with pre 4
    do_arm(4, 8'h80, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) sample(8'h10, 1);
    for (int i = 0; i < 12; i++) sample(8'h10, 1);
    check("t3_wrap", wr_addr, 0);
    for (int i = 0; i < 6; i++) sample(8'h10, 1);
    check("t3_still_armed", state_dbg, 2);
    sample(8'h90, 1);
    check("t3_trig_addr", trig_addr, 6);
    for (int i = 0; i < 11; i++) sample(8'h50, 1);
    check("t3_ready", buf_ready, 1);
    check("t3_rd_start", rd_addr, 2);
    do_reset();

    // pre = 15: readout straight after the trigger sample
    do_arm(15, 8'h80, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) sample(8'h10, 1);
    check("t3_pre15_armed", state_dbg, 2);
    sample(8'h90, 1);
    check("t3_pre15_state", state_dbg, 4);
    check("t3_pre15_ready", buf_ready, 1);
    check("t3_pre15_trig", trig_addr, 15);
    check("t3_pre15_rd", rd_addr, 0);
    do_reset();

    // auto trigger: samples on ARMED cycles 2,5,...,98,101
    do_arm(0, 8'h80, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 33; k++) begin
      tick(); tick();
      sample(8'h00, 1);
    end
    check("t4_no_early_trig", state_dbg, 2);
    tick(); tick();
    sample(8'h00, 1);
    check("t4_state_post", state_dbg, 3);
    check("t4_auto", auto_trig, 1);
    check("t4_trig_addr", trig_addr, 1);
    do_reset();

    // continuous re-arm; arm ignored in POST and READOUT
    do_arm(4, 8'h80, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) sample(8'h10, 1);
    sample(8'h90, 1);
    check("t5_trig_addr", trig_addr, 4);
    pre_count = 9;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    pre_count = 4;
    check("t5_arm_post_state", state_dbg, 3);
    check("t5_arm_post_trig", trig_addr, 4);
    for (int i = 0; i < 11; i++) sample(8'h60, 1);
    check("t5_state_ro", state_dbg, 4);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("t5_arm_ro_state", state_dbg, 4);
    check("t5_arm_ro_rd", rd_addr, 0);
    m_ra = 0;
    for (int i = 0; i < 16; i++) step(1);
    check("t5_rearm_state", state_dbg, 1);
    check("t5_rearm_ready", buf_ready, 0);
    check("t5_rearm_cap", capturing, 1);
    m_wa = '0;
    sample(8'h21, 1);
    check("t5_wr_next", wr_addr, 1);
    do_reset();

    // reset in POST abandons the capture, next arm starts at 0
    do_arm(0, 8'h80, 1'b1, 1'b0);
    tick();
    sample(8'h10, 1);
    sample(8'h90, 1);
    sample(8'h20, 1);
    sample(8'h30, 1);
    check("t6_in_post", state_dbg, 3);
    sample_valid = 1'b1;
    sample_data  = 8'h55;
    do_reset();
    do_arm(0, 8'h80, 1'b1, 1'b0);
    tick();
    check("t6_restart_addr", wr_addr, 0);
    sample(8'h66, 1);
    tick();
    check("t6_wr_q_drained", exp_wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
